// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low {g..a} patterns,
// scan slot indices and the snapshot record.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

    typedef struct packed {
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] hund;
        logic       sign;
        logic [1:0] cur;
    } snap_t;

    // Active-low anode select for one scan slot.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low 7-segment pattern; values above 9 render as 'E'.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    // Pure lookup, no state.
    always_comb begin
        pattern = SEG_E;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver with per-frame input snapshot.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       sign,
    input  logic [1:0] cursor,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 32'd1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic LZB_EN = 1'b1;
`else
    localparam logic LZB_EN = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       digit_r;
    logic             load_pending_r;
    snap_t            snap_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             frame_start_r;

    logic             tick_s;
    logic             load_s;
    logic [3:0]       digit_val_s;
    logic             blank_s;
    logic             minus_s;
    logic [6:0]       dec_pat_s;
    logic [6:0]       disp_pat_s;

    assign tick_s = (cnt_r == CNT_MAX);
    assign load_s = load_pending_r | (tick_s & (digit_r == D3));

    // Refresh counter and scan slot; both hold during the post-reset load cycle
    // so the first D0 slot is as long as every other slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r          <= '0;
            digit_r        <= D0;
            load_pending_r <= 1'b1;
        end else if (load_pending_r) begin
            load_pending_r <= 1'b0;
        end else if (tick_s) begin
            cnt_r   <= '0;
            digit_r <= digit_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Input snapshot, taken only at frame boundaries so a frame is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r        <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= load_s;
            if (load_s) begin
                snap_r <= '{ones: ones, tens: tens, hund: hundreds, sign: sign, cur: cursor};
            end else begin
                snap_r <= snap_r;
            end
        end
    end

    // Select the digit for the current slot and decide blank / minus overrides.
    always_comb begin
        digit_val_s = 4'd0;
        blank_s     = 1'b0;
        minus_s     = 1'b0;
        case (digit_r)
            D0: digit_val_s = snap_r.ones;
            D1: begin
                digit_val_s = snap_r.tens;
                blank_s     = LZB_EN & (snap_r.hund == 4'd0) & (snap_r.tens == 4'd0);
            end
            D2: begin
                digit_val_s = snap_r.hund;
                blank_s     = LZB_EN & (snap_r.hund == 4'd0);
            end
            D3: begin
                minus_s = snap_r.sign;
                blank_s = ~snap_r.sign;
            end
            default: begin
                digit_val_s = 4'd0;
                blank_s     = 1'b1;
            end
        endcase
    end

    seg7_decoder u_decoder (
        .bcd     (digit_val_s),
        .pattern (dec_pat_s)
    );

    // Apply overrides on top of the decoded pattern.
    always_comb begin
        disp_pat_s = dec_pat_s;
        if (minus_s) begin
            disp_pat_s = SEG_MINUS;
        end else if (blank_s) begin
            disp_pat_s = SEG_BLANK;
        end else begin
            disp_pat_s = dec_pat_s;
        end
    end

    // Registered display lines; kept dark until the first snapshot is in place.
    always_ff @(posedge clk) begin
        if (reset || load_pending_r) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= one_cold(digit_r);
            seg_r <= disp_pat_s;
            dp_r  <= (digit_r == snap_r.cur) ? 1'b0 : 1'b1;
        end
    end

    assign an          = an_r;
    assign seg         = seg_r;
    assign dp          = dp_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with REFRESH_DIV = 4.
// Honours SEG7_LEADING_ZERO_BLANK_EN when computing expected patterns.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    typedef struct packed {
        logic [3:0]      ones;
        logic [3:0]      tens;
        logic [3:0]      hund;
        logic            sign;
        logic [1:0]      cur;
        logic [3:0][6:0] seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       sign;
    logic [1:0] cursor;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int   checks;
    int   errors;
    vec_t vt[8];
    exp_t sb_q[$];
    logic [3:0] an_tab[4];

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .ones        (ones),
        .tens        (tens),
        .hundreds    (hundreds),
        .sign        (sign),
        .cursor      (cursor),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input exp_t exp, input logic fs_exp);
        checks++;
        if (an !== exp.an || seg !== exp.seg || dp !== exp.dp || frame_start !== fs_exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                     name, an, seg, dp, frame_start, exp.an, exp.seg, exp.dp, fs_exp);
        end
    endtask

    task automatic apply(input int vi);
        ones     = vt[vi].ones;
        tens     = vt[vi].tens;
        hundreds = vt[vi].hund;
        sign     = vt[vi].sign;
        cursor   = vt[vi].cur;
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int n = 0; n < 12 * DIV && !seen; n++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_frame: frame_start not seen within %0d cycles", 12 * DIV);
        end
    endtask

    // Entered on the negedge where frame_start is high; checks the whole frame.
    task automatic run_frame(input int vi, input int edit_ones);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{an: an_tab[k], seg: vt[vi].seg[k],
                             dp: (vt[vi].cur == k[1:0]) ? 1'b0 : 1'b1});
        end
        for (int k = 0; k < 4; k++) begin
            e = sb_q.pop_front();
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (k == 1 && c == 1 && edit_ones >= 0) ones = edit_ones[3:0];
                chk($sformatf("vec%0d_slot%0d_cyc%0d", vi, k, c), e, (k == 3 && c == DIV - 1));
            end
        end
    endtask

    initial begin
        exp_t off;
        checks = 0;
        errors = 0;
        off    = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        vt[0] = '{ones: 4'd3,  tens: 4'd2,  hund: 4'd1,  sign: 1'b1, cur: 2'd0,
                  seg: {7'b0111111, 7'b1111001, 7'b0100100, 7'b0110000}};
        vt[1] = '{ones: 4'd5,  tens: 4'd2,  hund: 4'd1,  sign: 1'b1, cur: 2'd0,
                  seg: {7'b0111111, 7'b1111001, 7'b0100100, 7'b0010010}};
        vt[2] = '{ones: 4'd12, tens: 4'd2,  hund: 4'd1,  sign: 1'b1, cur: 2'd0,
                  seg: {7'b0111111, 7'b1111001, 7'b0100100, 7'b0000110}};
        vt[3] = '{ones: 4'd7,  tens: 4'd0,  hund: 4'd0,  sign: 1'b0, cur: 2'd2,
                  seg: {7'b1111111, LZ, LZ, 7'b1111000}};
        vt[4] = '{ones: 4'd9,  tens: 4'd8,  hund: 4'd4,  sign: 1'b0, cur: 2'd3,
                  seg: {7'b1111111, 7'b0011001, 7'b0000000, 7'b0010000}};
        vt[5] = '{ones: 4'd6,  tens: 4'd15, hund: 4'd10, sign: 1'b1, cur: 2'd1,
                  seg: {7'b0111111, 7'b0000110, 7'b0000110, 7'b0000010}};
        vt[6] = '{ones: 4'd0,  tens: 4'd0,  hund: 4'd0,  sign: 1'b1, cur: 2'd1,
                  seg: {7'b0111111, LZ, LZ, 7'b1000000}};
        vt[7] = '{ones: 4'd4,  tens: 4'd0,  hund: 4'd5,  sign: 1'b0, cur: 2'd0,
                  seg: {7'b1111111, 7'b0010010, 7'b1000000, 7'b0011001}};

        // Reset held for three cycles, then released with vector 0 on the inputs.
        reset = 1'b1;
        apply(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i), off, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("release_cycle1", off, 1'b1);

        // First frame, with ones edited mid-frame; the edit shows one frame later.
        run_frame(0, 5);
        run_frame(1, -1);

        for (int vi = 2; vi < 8; vi++) begin
            apply(vi);
            wait_frame();
            run_frame(vi, -1);
        end

        // Reset mid-slot, then restart from D0.
        apply(3);
        wait_frame();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midslot_reset", off, 1'b0);
        @(negedge clk);
        chk("midslot_reset_hold", off, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rerelease_cycle1", off, 1'b1);
        @(negedge clk);
        chk("rerelease_d0", '{an: 4'b1110, seg: 7'b1111000, dp: 1'b1}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
